// File: rtl/ray_dispatch.sv
// Raster ray dispatcher: issues pixel coordinates under a credit limit and pairs returned
// ray directions with their coordinates. Define RAY_DISPATCH_STATS_EN for the credit-stall counter.
module ray_dispatch #(
  parameter int H_PIXELS     = 512,
  parameter int V_PIXELS     = 384,
  parameter int MAX_INFLIGHT = 128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        valid_out,
  input  logic [31:0] dir_x_in,
  input  logic [31:0] dir_y_in,
  input  logic [31:0] dir_z_in,
  input  logic        dir_valid_in,
  output logic [10:0] px_x_out,
  output logic [9:0]  px_y_out,
  output logic [31:0] px_dir_x_out,
  output logic [31:0] px_dir_y_out,
  output logic [31:0] px_dir_z_out,
  output logic        px_valid_out,
  input  logic        px_ready_in,
  output logic        px_last_out,
  output logic        overflow_out,
  output logic [31:0] stall_count_out
);

  localparam int AW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_INFLIGHT);
  localparam logic [10:0]   X_LAST     = 11'(H_PIXELS - 1);
  localparam logic [9:0]    Y_LAST     = 10'(V_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [10:0]   x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          valid_q;
  logic [10:0]   xo_q;
  logic [9:0]    yo_q;
  logic          overflow_q;
  logic          frame_done;

  logic [20:0]   cf_mem [MAX_INFLIGHT];
  logic [AW-1:0] cf_wr_q, cf_rd_q;
  logic [CW-1:0] cf_cnt_q;
  logic [116:0]  rf_mem [MAX_INFLIGHT];
  logic [AW-1:0] rf_wr_q, rf_rd_q;
  logic [CW-1:0] rf_cnt_q;
  logic [116:0]  rf_head;

  logic start_ok, can_issue, blocked, issue, at_last, accept;
  logic cf_empty, ret_ok;

  assign start_ok  = (state_q == IDLE) && start_in;
  assign can_issue = (state_q == ISSUE) && (credit_q < CREDIT_MAX);
  assign blocked   = (state_q == ISSUE) && !(credit_q < CREDIT_MAX);
  assign issue     = start_ok || can_issue;
  assign at_last   = (x_q == X_LAST) && (y_q == Y_LAST);
  assign cf_empty  = (cf_cnt_q == '0);
  assign ret_ok    = dir_valid_in && !cf_empty;
  assign accept    = px_valid_out && px_ready_in;

  // The start cycle issues (0,0) directly, so a 1x1 frame goes straight to DRAIN.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE:    if (start_in) state_d = at_last ? DRAIN : ISSUE;
      ISSUE:   if (can_issue && at_last) state_d = DRAIN;
      DRAIN:   if (credit_q == '0) begin
                 state_d    = IDLE;
                 frame_done = 1'b1;
               end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      if (at_last) begin
        x_d = '0;
        y_d = '0;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 10'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
    case ({issue, accept})
      2'b10:   credit_d = credit_q + CW'(1);
      2'b01:   credit_d = credit_q - CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      credit_q   <= '0;
      valid_q    <= 1'b0;
      xo_q       <= '0;
      yo_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      credit_q <= credit_d;
      valid_q  <= issue;
      if (issue) begin
        xo_q <= x_q;
        yo_q <= y_q;
      end
      if (dir_valid_in && cf_empty) overflow_q <= 1'b1;
    end
  end

  // Occupancy of both FIFOs is bounded by the credit count, so neither can overrun.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cf_wr_q  <= '0;
      cf_rd_q  <= '0;
      cf_cnt_q <= '0;
      rf_wr_q  <= '0;
      rf_rd_q  <= '0;
      rf_cnt_q <= '0;
    end else begin
      if (issue)  cf_wr_q <= cf_wr_q + AW'(1);
      if (ret_ok) cf_rd_q <= cf_rd_q + AW'(1);
      case ({issue, ret_ok})
        2'b10:   cf_cnt_q <= cf_cnt_q + CW'(1);
        2'b01:   cf_cnt_q <= cf_cnt_q - CW'(1);
        default: cf_cnt_q <= cf_cnt_q;
      endcase
      if (ret_ok) rf_wr_q <= rf_wr_q + AW'(1);
      if (accept) rf_rd_q <= rf_rd_q + AW'(1);
      case ({ret_ok, accept})
        2'b10:   rf_cnt_q <= rf_cnt_q + CW'(1);
        2'b01:   rf_cnt_q <= rf_cnt_q - CW'(1);
        default: rf_cnt_q <= rf_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (issue)  cf_mem[cf_wr_q] <= {x_q, y_q};
    if (ret_ok) rf_mem[rf_wr_q] <= {cf_mem[cf_rd_q], dir_x_in, dir_y_in, dir_z_in};
  end

  assign rf_head        = rf_mem[rf_rd_q];
  assign px_valid_out   = (rf_cnt_q != '0);
  assign px_x_out       = px_valid_out ? rf_head[116:106] : '0;
  assign px_y_out       = px_valid_out ? rf_head[105:96]  : '0;
  assign px_dir_x_out   = px_valid_out ? rf_head[95:64]   : '0;
  assign px_dir_y_out   = px_valid_out ? rf_head[63:32]   : '0;
  assign px_dir_z_out   = px_valid_out ? rf_head[31:0]    : '0;
  assign px_last_out    = px_valid_out && (rf_head[116:106] == X_LAST) && (rf_head[105:96] == Y_LAST);

  assign busy_out       = (state_q != IDLE);
  assign frame_done_out = frame_done;
  assign valid_out      = valid_q;
  assign x_out          = xo_q;
  assign y_out          = yo_q;
  assign overflow_out   = overflow_q;

`ifdef RAY_DISPATCH_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (blocked && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count_out = stall_q;
`else
  assign stall_count_out = '0;
`endif

endmodule

// File: tb/tb_ray_dispatch.sv
// Self-checking bench for ray_dispatch: a latency-configurable ray pipeline, random downstream
// readiness, and a queue-based reference model compared on every cycle.
module tb_ray_dispatch;

  localparam int H = 4;
  localparam int V = 2;
  localparam int M = 4;
  localparam int N = H * V;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        busy_out, frame_done_out, valid_out;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [31:0] dir_x_in, dir_y_in, dir_z_in;
  logic        dir_valid_in;
  logic [10:0] px_x_out;
  logic [9:0]  px_y_out;
  logic [31:0] px_dir_x_out, px_dir_y_out, px_dir_z_out;
  logic        px_valid_out, px_ready_in, px_last_out, overflow_out;
  logic [31:0] stall_count_out;

  logic        pipeDirValid, injDirValid;
  logic [31:0] pipeDx, pipeDy, pipeDz, injDx, injDy, injDz;

  assign dir_valid_in = pipeDirValid | injDirValid;
  assign dir_x_in     = injDirValid ? injDx : pipeDx;
  assign dir_y_in     = injDirValid ? injDy : pipeDy;
  assign dir_z_in     = injDirValid ? injDz : pipeDz;

  ray_dispatch #(.H_PIXELS(H), .V_PIXELS(V), .MAX_INFLIGHT(M)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .busy_out(busy_out), .frame_done_out(frame_done_out),
    .x_out(x_out), .y_out(y_out), .valid_out(valid_out),
    .dir_x_in(dir_x_in), .dir_y_in(dir_y_in), .dir_z_in(dir_z_in),
    .dir_valid_in(dir_valid_in),
    .px_x_out(px_x_out), .px_y_out(px_y_out),
    .px_dir_x_out(px_dir_x_out), .px_dir_y_out(px_dir_y_out), .px_dir_z_out(px_dir_z_out),
    .px_valid_out(px_valid_out), .px_ready_in(px_ready_in), .px_last_out(px_last_out),
    .overflow_out(overflow_out), .stall_count_out(stall_count_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ray pipeline: each issued coordinate returns a random direction pipeLat cycles later.
  typedef struct {
    int          due;
    logic [31:0] dx, dy, dz;
  } ret_t;

  ret_t pipeQ[$];
  int   pipeLat = 117;

  initial begin
    ret_t pr;
    pipeDirValid = 1'b0;
    pipeDx = '0; pipeDy = '0; pipeDz = '0;
    forever begin
      @(posedge clk_in);
      #1;
      if (rst_in) begin
        pipeQ.delete();
        pipeDirValid = 1'b0;
      end else begin
        if (valid_out) begin
          pr.due = cyc + pipeLat;
          pr.dx  = $urandom;
          pr.dy  = $urandom;
          pr.dz  = $urandom;
          pipeQ.push_back(pr);
        end
        if (pipeQ.size() > 0 && pipeQ[0].due == cyc) begin
          pr = pipeQ.pop_front();
          pipeDx = pr.dx; pipeDy = pr.dy; pipeDz = pr.dz;
          pipeDirValid = 1'b1;
        end else begin
          pipeDirValid = 1'b0;
        end
      end
    end
  end

  // 0: always ready, 1: never ready, 2: ready about 3 cycles in 4.
  int readyMode = 0;

  initial begin
    px_ready_in = 1'b1;
    forever begin
      @(posedge clk_in);
      #1;
      case (readyMode)
        0:       px_ready_in = 1'b1;
        1:       px_ready_in = 1'b0;
        default: px_ready_in = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference model: a frame is N raster-ordered issues gated by issued-minus-accepted < M;
  // returned directions pair with the oldest unreturned coordinate.
  typedef struct {
    int          idx;
    logic [31:0] dx, dy, dz;
  } res_t;

  bit          mBusy, mValid, mOverflow;
  int          mIssued, mAccepted;
  logic [31:0] mStall;
  int          coordQ[$];
  res_t        resQ[$];

  int valPulses = 0;
  int doneCount = 0;
  int lastCount = 0;
  int lastIdx   = -1;
  int delivered[$];

  always @(negedge clk_in) begin : compare
    res_t        r;
    res_t        hd;
    int          credit;
    bit          inIssue, acc, doIssue, done;
    logic [31:0] expStall;
    if (rst_in) begin
      mBusy = 0; mValid = 0; mOverflow = 0;
      mIssued = 0; mAccepted = 0; mStall = '0;
      coordQ.delete();
      resQ.delete();
    end else begin
      credit  = mIssued - mAccepted;
      inIssue = mBusy && (mIssued < N);
      done    = mBusy && (mIssued == N) && (credit == 0);
`ifdef RAY_DISPATCH_STATS_EN
      expStall = mStall;
`else
      expStall = '0;
`endif
      checkOutput("busy", 64'(busy_out), 64'(mBusy));
      checkOutput("frame_done", 64'(frame_done_out), 64'(done));
      checkOutput("valid", 64'(valid_out), 64'(mValid));
      if (mValid) begin
        checkOutput("x_out", 64'(x_out), 64'((mIssued - 1) % H));
        checkOutput("y_out", 64'(y_out), 64'((mIssued - 1) / H));
      end
      checkOutput("px_valid", 64'(px_valid_out), 64'(resQ.size() > 0));
      if (resQ.size() > 0) begin
        hd = resQ[0];
        checkOutput("px_x", 64'(px_x_out), 64'(hd.idx % H));
        checkOutput("px_y", 64'(px_y_out), 64'(hd.idx / H));
        checkOutput("px_dir_x", 64'(px_dir_x_out), 64'(hd.dx));
        checkOutput("px_dir_y", 64'(px_dir_y_out), 64'(hd.dy));
        checkOutput("px_dir_z", 64'(px_dir_z_out), 64'(hd.dz));
        checkOutput("px_last", 64'(px_last_out), 64'(hd.idx == N - 1));
      end else begin
        checkOutput("px_last_idle", 64'(px_last_out), 64'(0));
      end
      checkOutput("overflow", 64'(overflow_out), 64'(mOverflow));
      checkOutput("stall_count", 64'(stall_count_out), 64'(expStall));

      if (valid_out) valPulses++;
      if (frame_done_out) doneCount++;
      if (px_valid_out && px_ready_in) begin
        delivered.push_back(int'(px_y_out) * H + int'(px_x_out));
        if (px_last_out) begin
          lastCount++;
          lastIdx = int'(px_y_out) * H + int'(px_x_out);
        end
      end

      acc = (resQ.size() > 0) && px_ready_in;
      if (!mBusy && start_in) begin
        mIssued = 0; mAccepted = 0; mStall = '0;
        doIssue = 1;
      end else begin
        doIssue = inIssue && (credit < M);
        if (inIssue && credit >= M && mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
      end
      if (acc) begin
        void'(resQ.pop_front());
        mAccepted++;
      end
      if (dir_valid_in) begin
        if (coordQ.size() > 0) begin
          r.idx = coordQ.pop_front();
          r.dx = dir_x_in; r.dy = dir_y_in; r.dz = dir_z_in;
          resQ.push_back(r);
        end else begin
          mOverflow = 1;
        end
      end
      if (doIssue) begin
        coordQ.push_back(mIssued);
        mIssued++;
      end
      mValid = doIssue;
      mBusy  = mBusy ? !done : start_in;
    end
  end

  task automatic applyStimulus(input bit doStart, input bit doInj);
    @(posedge clk_in);
    #1;
    start_in    = doStart;
    injDirValid = doInj;
    if (doInj) begin
      injDx = $urandom; injDy = $urandom; injDz = $urandom;
    end
    @(posedge clk_in);
    #1;
    start_in    = 1'b0;
    injDirValid = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk_in);
      #1;
      if (!busy_out) begin
        seen = 1;
        break;
      end
    end
    checkOutput("idle_reached", 64'(seen), 64'(1));
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, "_count"}, 64'(delivered.size()), 64'(N));
    for (int i = 0; i < delivered.size(); i++)
      checkOutput({tag, "_order"}, 64'(delivered[i]), 64'(i));
  endtask

  task automatic doReset();
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    checkOutput("rst_busy", 64'(busy_out), 64'(0));
    checkOutput("rst_valid", 64'(valid_out), 64'(0));
    checkOutput("rst_x", 64'(x_out), 64'(0));
    checkOutput("rst_y", 64'(y_out), 64'(0));
    checkOutput("rst_px_valid", 64'(px_valid_out), 64'(0));
    checkOutput("rst_px_last", 64'(px_last_out), 64'(0));
    checkOutput("rst_px_x", 64'(px_x_out), 64'(0));
    checkOutput("rst_done", 64'(frame_done_out), 64'(0));
    checkOutput("rst_overflow", 64'(overflow_out), 64'(0));
    checkOutput("rst_stall", 64'(stall_count_out), 64'(0));
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, baseDone, baseLast;
    bit reached;
    rst_in = 1'b1;
    start_in = 1'b0;
    injDirValid = 1'b0;
    injDx = '0; injDy = '0; injDz = '0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("init_busy", 64'(busy_out), 64'(0));
    checkOutput("init_valid", 64'(valid_out), 64'(0));
    checkOutput("init_px_valid", 64'(px_valid_out), 64'(0));
    rst_in = 1'b0;

    $display("[TB] frame with 117-cycle pipeline, always ready");
    pipeLat = 117; readyMode = 0;
    delivered.delete();
    baseDone = doneCount; baseLast = lastCount;
    applyStimulus(1, 0);
    checkOutput("first_valid", 64'(valid_out), 64'(1));
    checkOutput("first_x", 64'(x_out), 64'(0));
    checkOutput("first_y", 64'(y_out), 64'(0));
    waitIdle(2000);
    checkFrame("f1");
    checkOutput("f1_done_pulses", 64'(doneCount - baseDone), 64'(1));
    checkOutput("f1_last_pulses", 64'(lastCount - baseLast), 64'(1));
    checkOutput("f1_last_idx", 64'(lastIdx), 64'(7));

    $display("[TB] downstream stalled, then released");
    pipeLat = 3; readyMode = 1;
    delivered.delete();
    base = valPulses;
    applyStimulus(1, 0);
    repeat (40) @(posedge clk_in);
    #1;
    checkOutput("stall_issues", 64'(valPulses - base), 64'(4));
`ifdef RAY_DISPATCH_STATS_EN
    checkOutput("stall_counting", 64'(stall_count_out >= 32'd30), 64'(1));
`endif
    readyMode = 0;
    waitIdle(500);
    checkFrame("f2");

    $display("[TB] start pulses during ISSUE and DRAIN");
    pipeLat = 4; readyMode = 2;
    delivered.delete();
    base = valPulses; baseDone = doneCount;
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    reached = 0;
    for (int i = 0; i < 300; i++) begin
      if (valPulses - base >= N) begin
        reached = 1;
        break;
      end
      @(posedge clk_in);
      #1;
    end
    checkOutput("all_issued", 64'(reached), 64'(1));
    applyStimulus(1, 0);
    waitIdle(500);
    repeat (5) @(posedge clk_in);
    #1;
    checkOutput("no_refire_busy", 64'(busy_out), 64'(0));
    checkOutput("no_refire_issues", 64'(valPulses - base), 64'(N));
    checkOutput("no_refire_done", 64'(doneCount - baseDone), 64'(1));
    checkFrame("f3");

    $display("[TB] random frames");
    for (int f = 0; f < 3; f++) begin
      pipeLat = $urandom_range(1, 10);
      readyMode = 2;
      delivered.delete();
      applyStimulus(1, 0);
      waitIdle(1000);
      checkFrame("rnd");
    end

    $display("[TB] stray direction while idle");
    readyMode = 0;
    applyStimulus(0, 1);
    checkOutput("ovf_set", 64'(overflow_out), 64'(1));
    checkOutput("ovf_no_px", 64'(px_valid_out), 64'(0));
    pipeLat = $urandom_range(1, 6);
    readyMode = 2;
    delivered.delete();
    applyStimulus(1, 0);
    waitIdle(1000);
    checkFrame("ovf_frame");
    checkOutput("ovf_sticky", 64'(overflow_out), 64'(1));
    doReset();
    checkOutput("ovf_cleared", 64'(overflow_out), 64'(0));

    $display("[TB] reset mid-frame");
    pipeLat = 5; readyMode = 0;
    base = valPulses;
    applyStimulus(1, 0);
    reached = 0;
    for (int i = 0; i < 50; i++) begin
      if (valPulses - base >= 3) begin
        reached = 1;
        break;
      end
      @(posedge clk_in);
      #1;
    end
    checkOutput("three_issued", 64'(reached), 64'(1));
    doReset();
    delivered.delete();
    applyStimulus(1, 0);
    checkOutput("restart_valid", 64'(valid_out), 64'(1));
    checkOutput("restart_x", 64'(x_out), 64'(0));
    checkOutput("restart_y", 64'(y_out), 64'(0));
    waitIdle(500);
    checkFrame("f_rst");

    repeat (3) @(posedge clk_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ray_dispatch.md
RAY_DISPATCH -- requirements
Module: ray_dispatch

Interface
REQ-001 Parameter H_PIXELS, default 512: pixels per scanline; range 1..2047.
REQ-002 Parameter V_PIXELS, default 384: scanlines per frame; range 1..1023.
REQ-003 Parameter MAX_INFLIGHT, default 128: credit limit and depth of both internal FIFOs; power of 2, range 2..256.
REQ-004 Port clk_in, input, 1: the single clock.
REQ-005 Port rst_in, input, 1: asynchronous active-high reset.
REQ-006 Port start_in, input, 1: one-cycle frame start request.
REQ-007 Port busy_out, output, 1: high whenever state is not IDLE.
REQ-008 Port frame_done_out, output, 1: one-cycle pulse at frame completion.
REQ-009 Ports x_out, output, 11, and y_out, output, 10: pixel coordinate issued to the ray pipeline.
REQ-010 Port valid_out, output, 1: coordinate qualifier to the ray pipeline; the pipeline has no backpressure.
REQ-011 Ports dir_x_in, dir_y_in, dir_z_in, input, 32 each: returned normalized direction, IEEE-754 single.
REQ-012 Port dir_valid_in, input, 1: direction qualifier; results return in issue order.
REQ-013 Ports px_x_out (11), px_y_out (10), px_dir_x_out, px_dir_y_out, px_dir_z_out (32 each), outputs: coordinate paired with its direction.
REQ-014 Port px_valid_out, output, 1; port px_ready_in, input, 1: downstream valid/ready handshake.
REQ-015 Port px_last_out, output, 1: high with the frame's final pixel.
REQ-016 Port overflow_out, output, 1: sticky error flag.
REQ-017 Port stall_count_out, output, 32: credit-stall cycle count.

Function
REQ-018 FSM states IDLE, ISSUE, DRAIN; transitions IDLE->ISSUE on start_in, ISSUE->DRAIN after the (H_PIXELS-1, V_PIXELS-1) issue, DRAIN->IDLE when credit count is 0.
REQ-019 start_in outside IDLE is ignored.
REQ-020 Issue order is raster: x increments first, wraps H_PIXELS-1 -> 0 with y+1; first coordinate (0,0).
REQ-021 valid_out is registered; the first issue occurs the cycle after start_in is sampled in IDLE.
REQ-022 Credit count = coordinates issued minus pixels accepted downstream (px_valid_out & px_ready_in); issue in ISSUE only when count < MAX_INFLIGHT.
REQ-023 Simultaneous issue and downstream acceptance leaves count unchanged.
REQ-024 Each issue pushes {x,y} into the coordinate FIFO; each dir_valid_in pops it and pushes {x,y,dir} into the result FIFO in the same cycle.
REQ-025 dir_valid_in with an empty coordinate FIFO sets overflow_out, pushes nothing, and changes no count.
REQ-026 The result FIFO head drives the px_* ports; earliest px_valid_out is the cycle after the push; px_* are held stable while px_valid_out & !px_ready_in.
REQ-027 px_last_out is high only with the pixel whose coordinate is (H_PIXELS-1, V_PIXELS-1).
REQ-028 frame_done_out pulses in the DRAIN->IDLE transition cycle; busy_out falls the cycle after that.

Reset
REQ-029 Asserting rst_in immediately forces IDLE, empties both FIFOs, and zeroes the credit count, both counters, all outputs, overflow_out and stall_count_out, including mid-frame.
REQ-030 After reset release, the first start_in begins a fresh frame at (0,0).

Configuration
REQ-031 With RAY_DISPATCH_STATS_EN defined, stall_count_out increments each ISSUE cycle blocked by credit, saturates at 0xFFFFFFFF, and clears on start_in accepted in IDLE.
REQ-032 Without RAY_DISPATCH_STATS_EN, stall_count_out is constant 0 and no counter logic is synthesized.

Verification (bench parameters H=4, V=2, MAX_INFLIGHT=4 unless stated)
REQ-033 start pulse, pipeline model with latency 117 cycles, px_ready_in=1 -> 8 outputs in raster order (0,0)..(3,1); last output has px_last_out=1; frame_done_out pulses once.
REQ-034 px_ready_in=0 throughout -> exactly 4 issues, then valid_out stays 0; with STATS_EN, stall_count_out increments each cycle.
REQ-035 Release px_ready_in=1 after the REQ-034 stall -> issues resume; all 8 pixels are delivered with no loss or duplication.
REQ-036 dir_valid_in pulse while IDLE -> overflow_out=1, no px_valid_out; the flag holds until rst_in.
REQ-037 rst_in asserted after 3 issues -> all outputs 0 asynchronously; a new start then issues (0,0).
REQ-038 start_in pulsed during ISSUE and DRAIN -> no effect; a single frame of 8 pixels is delivered.
